// File: rtl/word_byte_tx_if.sv
// Word-in / byte-out handshake bundle for the byte-stream load-port transmitter.
interface word_byte_tx_if #(
   parameter int unsigned WORD_BYTES = 8
);
   logic [WORD_BYTES*8-1:0] word_in;
   logic                    word_valid;
   logic                    word_ready;
   logic [7:0]              byte_out;
   logic                    byte_valid;
   logic                    byte_last;
   logic                    byte_ready;

   // Transmitter side: consumes words, produces the byte stream.
   modport master (
      input  word_in, word_valid, byte_ready,
      output word_ready, byte_out, byte_valid, byte_last
   );

   // Host/receiver side.
   modport slave (
      output word_in, word_valid, byte_ready,
      input  word_ready, byte_out, byte_valid, byte_last
   );
endinterface

// File: rtl/word_byte_tx.sv
// Serializes one WORD_BYTES-byte word into a valid/ready byte stream with a last-byte marker,
// an optional post-frame idle gap, an abort flush and a wrapping completed-frame counter.
module word_byte_tx #(
   parameter int unsigned WORD_BYTES = 8,
   parameter bit          MSB_FIRST  = 1'b0,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_abort,
   word_byte_tx_if.master        io_bus,
   output logic                  o_busy,
   output logic [7:0]            o_frame_count
);
   localparam int unsigned    WordW   = WORD_BYTES * 8;
   localparam int unsigned    IdxW    = $clog2(WORD_BYTES);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(WORD_BYTES - 1);
   localparam logic [7:0]     GapInit = 8'(GAP_CYCLES);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StGap  = 2'd2
   } state_e;

   state_e            r_state;
   state_e            w_state_nxt;
   logic [WordW-1:0]  r_shift;
   logic [IdxW-1:0]   r_idx;
   logic [7:0]        r_gap;
   logic [7:0]        r_frame_count;

   logic              w_word_ready;
   logic              w_accept;
   logic              w_last;
   logic              w_byte_hs;

   // Handshake qualifiers; abort suppresses both the word accept and byte handshakes.
   always_comb begin
      w_word_ready = (r_state == StIdle) && rst_n;
      w_accept     = w_word_ready && io_bus.word_valid && !i_abort;
      w_last       = (r_idx == LastIdx);
      w_byte_hs    = (r_state == StSend) && io_bus.byte_ready && !i_abort;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept) w_state_nxt = StSend;
         end
         StSend: begin
            if (i_abort) begin
               w_state_nxt = StIdle;
            end else if (io_bus.byte_ready && w_last) begin
               w_state_nxt = (GAP_CYCLES == 0) ? StIdle : StGap;
            end
         end
         StGap: begin
            // Gap counter is loaded with GAP_CYCLES, so leaving at 1 gives exactly that many cycles.
            if (i_abort || (r_gap == 8'd1)) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // Datapath: shift register, byte index, gap counter and frame counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shift       <= '0;
         r_idx         <= '0;
         r_gap         <= '0;
         r_frame_count <= '0;
      end else if (w_accept) begin
         r_shift <= io_bus.word_in;
         r_idx   <= '0;
      end else if (w_byte_hs) begin
         if (w_last) begin
            r_frame_count <= r_frame_count + 8'd1;
            r_gap         <= GapInit;
         end else begin
            r_shift <= MSB_FIRST ? (r_shift << 8) : (r_shift >> 8);
            r_idx   <= r_idx + IdxW'(1);
         end
      end else if ((r_state == StGap) && !i_abort) begin
         r_gap <= r_gap - 8'd1;
      end
   end

   // Outputs; byte_out is forced to zero outside SEND so idle/reset shows a clean bus.
   always_comb begin
      io_bus.word_ready = w_word_ready;
      io_bus.byte_valid = (r_state == StSend);
      io_bus.byte_last  = (r_state == StSend) && w_last;
      io_bus.byte_out   = '0;
      if (r_state == StSend) begin
         io_bus.byte_out = MSB_FIRST ? r_shift[WordW-1 -: 8] : r_shift[7:0];
      end
      o_busy        = (r_state != StIdle);
      o_frame_count = r_frame_count;
   end
endmodule

// File: tb/tb_word_byte_tx.sv
// Runs three transmitter configurations off shared stimulus and checks every cycle against a
// queue-based model: a frame is a queue of bytes drained by byte_ready, then an idle gap.
module tb_word_byte_tx;
   localparam int NI = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] word;
   logic         word_valid;
   logic         abort;
   logic         byte_ready;

   logic [7:0]   fc   [NI];
   logic         busy [NI];
   logic [19:0]  obs  [NI];

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] mq   [NI][$];
   int         mgap [NI];
   int         mfc  [NI];
   logic [7:0] rx0  [$];

   always #5 clk = ~clk;

   word_byte_tx_if #(.WORD_BYTES(8)) if0 ();
   word_byte_tx_if #(.WORD_BYTES(8)) if1 ();
   word_byte_tx_if #(.WORD_BYTES(2)) if2 ();

   assign if0.word_in    = word[63:0];
   assign if0.word_valid = word_valid;
   assign if0.byte_ready = byte_ready;
   assign if1.word_in    = word[63:0];
   assign if1.word_valid = word_valid;
   assign if1.byte_ready = byte_ready;
   assign if2.word_in    = word[15:0];
   assign if2.word_valid = word_valid;
   assign if2.byte_ready = byte_ready;

   word_byte_tx #(.WORD_BYTES(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u0 (
      .clk(clk), .rst_n(rst_n), .i_abort(abort), .io_bus(if0.master),
      .o_busy(busy[0]), .o_frame_count(fc[0]));
   word_byte_tx #(.WORD_BYTES(8), .MSB_FIRST(1'b1), .GAP_CYCLES(3)) u1 (
      .clk(clk), .rst_n(rst_n), .i_abort(abort), .io_bus(if1.master),
      .o_busy(busy[1]), .o_frame_count(fc[1]));
   word_byte_tx #(.WORD_BYTES(2), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u2 (
      .clk(clk), .rst_n(rst_n), .i_abort(abort), .io_bus(if2.master),
      .o_busy(busy[2]), .o_frame_count(fc[2]));

   assign obs[0] = {if0.word_ready, if0.byte_valid, if0.byte_last, busy[0], if0.byte_out, fc[0]};
   assign obs[1] = {if1.word_ready, if1.byte_valid, if1.byte_last, busy[1], if1.byte_out, fc[1]};
   assign obs[2] = {if2.word_ready, if2.byte_valid, if2.byte_last, busy[2], if2.byte_out, fc[2]};

   function automatic int wb_of(int k);
      return (k == 2) ? 2 : 8;
   endfunction

   function automatic bit msb_of(int k);
      return (k == 1);
   endfunction

   function automatic int gap_of(int k);
      return (k == 1) ? 3 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected {word_ready, byte_valid, byte_last, busy, byte_out, frame_count}.
   function automatic logic [19:0] model_out(int k);
      bit         mbusy;
      logic [7:0] b;
      mbusy = (mq[k].size() > 0) || (mgap[k] > 0);
      b     = (mq[k].size() > 0) ? mq[k][0] : 8'h00;
      return {rst_n && !mbusy, mq[k].size() > 0, mq[k].size() == 1, mbusy, b, 8'(mfc[k])};
   endfunction

   task automatic model_step();
      int idx;
      for (int k = 0; k < NI; k++) begin
         if (!rst_n) begin
            mq[k].delete();
            mgap[k] = 0;
            mfc[k]  = 0;
         end else if ((mq[k].size() > 0) || (mgap[k] > 0)) begin
            if (abort) begin
               mq[k].delete();
               mgap[k] = 0;
            end else if (mq[k].size() > 0) begin
               if (byte_ready) begin
                  mq[k].delete(0);
                  if (mq[k].size() == 0) begin
                     mfc[k]  = (mfc[k] + 1) % 256;
                     mgap[k] = gap_of(k);
                  end
               end
            end else begin
               mgap[k]--;
            end
         end else if (word_valid && !abort) begin
            for (int i = 0; i < wb_of(k); i++) begin
               idx = msb_of(k) ? (wb_of(k) - 1 - i) : i;
               mq[k].push_back(word[idx*8 +: 8]);
            end
         end
      end
   endtask

   // Called at a negedge with stimulus set: check, clock, advance model, return at next negedge.
   task automatic tick();
      #1;
      for (int k = 0; k < NI; k++) chk($sformatf("u%0d", k), 32'(obs[k]), 32'(model_out(k)));
      if (if0.byte_valid && byte_ready) rx0.push_back(if0.byte_out);
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic send_one(input logic [127:0] w);
      word       = w;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
   endtask

   task automatic chk_rx0(input string tag, input logic [63:0] exp);
      logic [63:0] acc;
      acc = '0;
      chk({tag, "_n"}, 32'(rx0.size()), 32'd8);
      for (int i = 0; i < 8; i++) acc[i*8 +: 8] = (i < rx0.size()) ? rx0[i] : 8'h00;
      chk({tag, "_lo"}, acc[31:0], exp[31:0]);
      chk({tag, "_hi"}, acc[63:32], exp[63:32]);
   endtask

   initial begin
      bit saw255;
      rst_n      = 1'b0;
      word       = '0;
      word_valid = 1'b0;
      abort      = 1'b0;
      byte_ready = 1'b0;
      for (int k = 0; k < NI; k++) begin
         mgap[k] = 0;
         mfc[k]  = 0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state.
      chk("rst_wr", 32'(if0.word_ready), 32'd0);
      chk("rst_bo", 32'(if0.byte_out), 32'd0);
      chk("rst_fc", 32'(fc[0]), 32'd0);
      tick();

      // Basic LSB-first (u0) / MSB-first (u1) with byte_ready held high.
      rst_n      = 1'b1;
      byte_ready = 1'b1;
      send_one(128'h0807060504030201);
      rx0.delete();
      repeat (14) tick();
      for (int i = 0; i < 8; i++) begin
         chk("lsb_byte", 32'((i < rx0.size()) ? rx0[i] : 8'h00), 32'(i + 1));
      end
      chk("lsb_fc", 32'(fc[0]), 32'd1);

      // Backpressure: byte_ready 1,0,0,1,0,0,...
      word = 128'hDEADBEEF3F800000;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      rx0.delete();
      for (int i = 0; i < 30; i++) begin
         byte_ready = (i % 3 == 0);
         tick();
      end
      byte_ready = 1'b1;
      repeat (6) tick();
      chk_rx0("bp", 64'hDEADBEEF3F800000);

      // Abort after three bytes, then a full frame.
      send_one(128'h1122334455667788);
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_bv", 32'(if0.byte_valid), 32'd0);
      chk("abort_fc", 32'(fc[0]), 32'd2);
      repeat (4) tick();
      rx0.delete();
      send_one(128'hA5C3_0F1E_7788_9900);
      repeat (12) tick();
      chk_rx0("post_abort", 64'hA5C30F1E77889900);
      chk("post_abort_fc", 32'(fc[0]), 32'd3);

      // Reset mid-frame.
      send_one(128'h0123456789ABCDEF);
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rstmid_fc", 32'(fc[0]), 32'd0);
      chk("rstmid_bv", 32'(if0.byte_valid), 32'd0);
      chk("rstmid_busy", 32'(busy[0]), 32'd0);
      repeat (4) tick();

      // Abort coincident with the last-byte handshake of u0.
      send_one(128'hFEDCBA9876543210);
      repeat (7) tick();
      chk("last_pre", 32'(if0.byte_last), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("last_abort_fc", 32'(fc[0]), 32'd0);
      repeat (4) tick();

      // Counter wrap: 256 back-to-back 2-byte frames on u2 (period 3 cycles).
      rst_n = 1'b0;
      tick();
      rst_n      = 1'b1;
      word_valid = 1'b1;
      byte_ready = 1'b1;
      saw255     = 1'b0;
      for (int i = 0; i < 768; i++) begin
         word = {$urandom(), $urandom(), $urandom(), $urandom()};
         tick();
         if (fc[2] == 8'd255) saw255 = 1'b1;
      end
      chk("wrap_255", 32'(saw255), 32'd1);
      chk("wrap_0", 32'(fc[2]), 32'd0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rst_n      = ($urandom_range(199) != 0);
         abort      = ($urandom_range(39) == 0);
         word_valid = ($urandom_range(2) != 0);
         byte_ready = ($urandom_range(3) != 0);
         word       = {$urandom(), $urandom(), $urandom(), $urandom()};
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
